// File: rtl/timer_mc_if.sv
// timer_mc_if: register-bus and interrupt bundle between a bus master and the timer block
interface timer_mc_if #(
    parameter int NUM_CH = 4
);
    logic [31:0]       wdata;
    logic [31:0]       waddr;
    logic [31:0]       raddr;
    logic              we;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] int_vec;
    logic              int_sig;
    modport master (output wdata, waddr, raddr, we, input rdata, int_vec, int_sig);
    modport slave (input wdata, waddr, raddr, we, output rdata, int_vec, int_sig);
endinterface

// File: rtl/timer_mc.sv
// timer_mc: multi-channel prescaled timer with memory-mapped CTRL/COUNT/VALUE/PRESC registers
module timer_mc #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter int          PRESC_W   = 16
) (
    input logic       clk,
    input logic       rst,
    timer_mc_if.slave bus
);
    logic [31:0]        woff, roff, rd;
    logic [1:0]         wreg;
    logic [NUM_CH-1:0]  en, ie, pend, mode, wsel, tick, expire, int_v;
    logic [CNT_W-1:0]   count [NUM_CH];
    logic [CNT_W-1:0]   value [NUM_CH];
    logic [PRESC_W-1:0] presc [NUM_CH];
    logic [PRESC_W-1:0] pcnt  [NUM_CH];

    assign woff  = bus.waddr - BASE_ADDR;
    assign roff  = bus.raddr - BASE_ADDR;
    assign wreg  = woff[3:2];
    assign int_v = pend & ie;

    always_comb begin
        wsel   = '0;
        tick   = '0;
        expire = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            wsel[n]   = bus.we && woff[31:8] == 24'd0 && woff[7:4] == 4'(n) && woff[1:0] == 2'd0;
            tick[n]   = en[n] && pcnt[n] == presc[n];
            // a COUNT write on the same cycle overrides the tick, so no expiry either
            expire[n] = tick[n] && !(wsel[n] && wreg == 2'd1) && count[n] == value[n];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            en   <= '0;
            ie   <= '0;
            pend <= '0;
            mode <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                count[n] <= '0;
                value[n] <= '0;
                presc[n] <= '0;
                pcnt[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (wsel[n] && wreg == 2'd0) begin
                    en[n]   <= bus.wdata[0];
                    ie[n]   <= bus.wdata[1];
                    mode[n] <= bus.wdata[3];
                end else if (expire[n] && mode[n]) begin
                    en[n] <= 1'b0;
                end
                pend[n] <= expire[n] || (pend[n] && !(wsel[n] && wreg == 2'd0 && bus.wdata[2]));
                if (wsel[n] && wreg == 2'd1)
                    count[n] <= bus.wdata[CNT_W-1:0];
                else if (tick[n])
                    count[n] <= expire[n] ? '0 : count[n] + CNT_W'(1);
                if (wsel[n] && wreg == 2'd2)
                    value[n] <= bus.wdata[CNT_W-1:0];
                if (wsel[n] && wreg == 2'd3)
                    presc[n] <= bus.wdata[PRESC_W-1:0];
                pcnt[n] <= (!en[n] || tick[n]) ? '0 : pcnt[n] + PRESC_W'(1);
            end
        end
    end

    always_comb begin
        rd = (roff == 32'h100) ? 32'(int_v) : '0;
        for (int n = 0; n < NUM_CH; n++)
            if (roff[31:8] == 24'd0 && roff[7:4] == 4'(n) && roff[1:0] == 2'd0)
                rd = roff[3:2] == 2'd0 ? {28'd0, mode[n], pend[n], ie[n], en[n]} :
                     roff[3:2] == 2'd1 ? 32'(count[n]) :
                     roff[3:2] == 2'd2 ? 32'(value[n]) : 32'(presc[n]);
    end

    assign bus.rdata   = rst ? rd : '0;
    assign bus.int_vec = rst ? int_v : '0;
    assign bus.int_sig = |bus.int_vec;
endmodule

// File: doc/timer_mc.md
TIMER_MC -- requirements
Module: timer_mc

Interface
REQ-001 SHALL provide parameter BASE_ADDR, default 32'h10000000, register block base address.
REQ-002 SHALL provide parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-003 SHALL provide parameter CNT_W, default 32, counter/compare width (8..32).
REQ-004 SHALL provide parameter PRESC_W, default 16, prescaler width (1..16).
REQ-005 SHALL have ports: clk  input  1  clock; rst  input  1  synchronous active-low reset.
REQ-006 SHALL have ports: wdata  input  32  write data; waddr  input  32  write address; raddr  input  32  read address; we  input  1  write strobe.
REQ-007 SHALL have ports: rdata  output  32  read data; int_vec  output  NUM_CH  per-channel interrupt; int_sig  output  1  OR of int_vec.
REQ-008 One clock (clk); reset is synchronous and active-low (rst); all state SHALL update only on posedge clk.

Function
REQ-009 Channel n registers SHALL sit at BASE_ADDR + 0x10*n: CTRL +0x0, COUNT +0x4, VALUE +0x8, PRESC +0xC.
REQ-010 Global STATUS SHALL sit at BASE_ADDR + 0x100, read-only, bit n = int_vec[n], upper bits 0.
REQ-011 CTRL bits SHALL be: [0] enable, [1] int enable, [2] pending (W1C), [3] mode (0 periodic, 1 one-shot); other bits read 0.
REQ-012 CTRL write SHALL load bits [0],[1],[3] from wdata; wdata[2]=1 clears pending, wdata[2]=0 leaves pending unchanged.
REQ-013 VALUE, PRESC, COUNT SHALL be writable; writes take wdata low bits; reads SHALL zero-extend to 32 bits.
REQ-014 Per channel, while enable=1, prescaler counter SHALL increment each cycle; when it equals PRESC it SHALL reset to 0 and assert a one-cycle tick.
REQ-015 PRESC=0 SHALL yield a tick every enabled cycle; PRESC=k SHALL yield a tick every k+1 cycles.
REQ-016 On tick with COUNT != VALUE, COUNT SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-017 On tick with COUNT == VALUE (expiry), COUNT SHALL become 0 and pending SHALL set to 1.
REQ-018 On expiry in one-shot mode, enable SHALL clear to 0 in the same cycle; periodic mode SHALL keep enable=1.
REQ-019 While enable=0, COUNT SHALL hold and the prescaler counter SHALL be held at 0.
REQ-020 A COUNT write coinciding with a tick SHALL win; COUNT takes wdata, no increment, no expiry that cycle.
REQ-021 A CTRL pending-clear coinciding with expiry SHALL leave pending=1 (hardware set wins).
REQ-022 A CTRL write coinciding with one-shot expiry SHALL take written enable value.
REQ-023 int_vec[n] SHALL be combinational: enable-independent pending & int enable of channel n; int_sig = OR of int_vec.
REQ-024 rdata SHALL be combinational from raddr; unmapped addresses and channel indices >= NUM_CH SHALL read 0; writes to them SHALL be ignored.
REQ-025 Writes to STATUS SHALL be ignored.

Reset
REQ-026 On clk edge with rst=0, all CTRL, COUNT, VALUE, PRESC and prescaler counters SHALL become 0, mid-operation included.
REQ-027 While rst=0, rdata SHALL be 0 and int_vec, int_sig SHALL be 0.

Verification
REQ-028 Ch0 VALUE=3, PRESC=0, CTRL=0x3 -> COUNT 0,1,2,3,0; pending=1 and int_sig=1 on cycle after COUNT reads 3; repeats every 4 cycles.
REQ-029 Ch1 VALUE=2, PRESC=4, CTRL=0xB (one-shot) -> COUNT steps every 5 cycles; after expiry enable=0, COUNT=0 held, int_vec=4'b0010.
REQ-030 Ch0 pending set, write CTRL=0x7 on same cycle as next expiry -> pending stays 1; write CTRL=0x7 on non-expiry cycle -> pending 0, int_sig 0.
REQ-031 CNT_W=8, VALUE=5, write COUNT=0x10, enable -> COUNT wraps 0xFF->0x00, expires at 5; read of COUNT upper 24 bits = 0.
REQ-032 Channels 0 and 2 run concurrently with different VALUE; STATUS reads 0x5 when both pending; read of BASE+0x40 (NUM_CH=4) returns 0.
REQ-033 Assert rst=0 mid-count with pending set -> next cycle all registers read 0, int_sig=0; release -> timers idle until re-enabled.
